alu_cmd_driver: RTL and testbench
=================================

Name: alu_cmd_driver

Overview:
Initiator side of the sequential ALU operand/enable/done interface. It accepts ALU commands through a valid/ready port and buffers them in a small FIFO. It issues one command at a time to the ALU as a single-cycle en pulse with stable operands, waits for done, and returns the 32-bit result on a valid/ready response port. Sits between a host/sequencer and the ALU, replacing hand-timed stimulus with a handshake-driven master.

Parameters:
DEPTH, 4, command FIFO entries (power of 2, >=2)
TIMEOUT, 63, max cycles waited for alu_done after en before aborting
OPW, 16, operand width; result width fixed at 2*OPW

Ports:
clk  in  1  system clock, rising edge
nrst  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  FIFO not full
cmd_opA  in  OPW  operand A, two's complement
cmd_opB  in  OPW  operand B, two's complement
cmd_opcode  in  2  00 add, 01 mul, 10 div, 11 cmp
alu_opA  out  OPW  to ALU opA
alu_opB  out  OPW  to ALU opB
alu_opcode  out  2  to ALU opcode
alu_en  out  1  one-cycle start pulse
alu_res  in  2*OPW  ALU result
alu_done  in  1  ALU completion
rsp_valid  out  1  result available
rsp_ready  in  1  consumer accepts result
rsp_res  out  2*OPW  captured result (0 on timeout)
rsp_opcode  out  2  opcode of completed command
rsp_err  out  1  1 = timeout abort
busy  out  1  FSM not IDLE or FIFO non-empty

Behaviour:
- Reset (nrst low, async): FSM to IDLE; FIFO emptied; every output 0 except cmd_ready=1. Reset mid-operation abandons the in-flight command; no response is produced.
- FIFO: push when cmd_valid&&cmd_ready; pop only in IDLE when non-empty. cmd_ready=!full. Push and pop in the same cycle are both honoured when not full. Pointers carry an extra wrap bit for full/empty.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if FIFO non-empty, pop the head into alu_opA/opB/opcode registers -> ISSUE.
- ISSUE: alu_en=1 for exactly this cycle; clear the timeout counter -> WAIT.
- WAIT: alu_done is sampled from the cycle after the en pulse; a done in the en cycle itself is ignored.
  - On alu_done=1: capture alu_res into rsp_res, rsp_err=0 -> RESP.
  - Else the counter increments; when the counter reaches TIMEOUT: rsp_res=0, rsp_err=1 -> RESP.
- RESP: rsp_valid=1; rsp_res, rsp_opcode and rsp_err are held stable until rsp_ready. On rsp_valid&&rsp_ready -> IDLE. The next issue occurs no earlier than the following cycle.
- alu_opA/opB/opcode stay stable from ISSUE through RESP exit, because the ALU may resample them.
- Minimum per-command latency: 1 (pop) + 1 (en) + 1 (done) + 1 (resp) = 4 cycles with rsp_ready held high.
- No arithmetic is performed on data; all values pass through unchanged.

Optional Feature:
ALU_CMD_DRIVER_STATS_EN
- Defined: adds outputs stat_ops [15:0] and stat_timeouts [7:0].
  - stat_ops counts completed responses; stat_timeouts counts err responses.
  - Both saturate (no wrap) and clear on nrst.
- Undefined: the outputs and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - opcode constants OP_ADD=2'b00, OP_MUL=2'b01, OP_DIV=2'b10, OP_CMP=2'b11;
  - OPW default;
  - FSM state encoding;
  - the command struct {opA, opB, opcode}.
- Sub-module cmd_fifo: parameterised synchronous FIFO with async active-low reset, exposing full/empty/push/pop. The FSM and timeout counter stay in the top module.

Test Plan:
(Bench uses a behavioural ALU model: done pulses N cycles after en; the result is pass-through.)
- Add, N=1: opA=111, opB=135, opcode 00, model res=246 -> one en pulse; rsp_valid with rsp_res=246, rsp_err=0, rsp_opcode=00; 4 cycles from push with rsp_ready=1.
- Mul back-to-back, N=17: push (135,111,01) then (135,-111,01), model res 14985 / -14985 -> two en pulses at least 19 cycles apart; responses in order 0x00003A89 then 0xFFFFC577.
- Backpressure/full, DEPTH=4: rsp_ready=0, push 6 divide commands (0x7EED, 0x105) -> first completes and holds in RESP; 4 more fill the FIFO; cmd_ready=0 blocks the 6th. Releasing rsp_ready drains all 5 in order.
- Timeout: model never asserts done, TIMEOUT=63 -> rsp_valid TIMEOUT cycles after WAIT entry, rsp_err=1, rsp_res=0; the next command issues normally.
- Reset mid-op: nrst low during WAIT of a mul -> all outputs 0, cmd_ready=1 asynchronously; no response after release; a fresh cmp (135,111,11) completes normally.
- Done ignored in en cycle: model asserts done in the same cycle as en and again 2 cycles later -> result captured on the later done only.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcodes, FSM encoding and
// the command payload carried through the FIFO.
package alu_pkg;

  localparam int unsigned OPW_DEFAULT = 16;
  localparam int unsigned OPCODE_W    = 2;

  localparam logic [OPCODE_W-1:0] OP_ADD = 2'b00;
  localparam logic [OPCODE_W-1:0] OP_MUL = 2'b01;
  localparam logic [OPCODE_W-1:0] OP_DIV = 2'b10;
  localparam logic [OPCODE_W-1:0] OP_CMP = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  // Field order matches the packing used on the FIFO data path.
  typedef struct packed {
    logic [OPW_DEFAULT-1:0] opA;
    logic [OPW_DEFAULT-1:0] opB;
    logic [OPCODE_W-1:0]    opcode;
  } cmd_t;

  localparam int unsigned CMD_W_DEFAULT = $bits(cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with async active-low reset. Read data is the
// current head; pointers carry an extra wrap bit to separate full from empty.
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 34
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW-1:0] wr_nxt;
  logic [PW-1:0] rd_nxt;
  logic [W-1:0]  mem [DEPTH];
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign wr_nxt  = wr_q + PW'(do_push);
  assign rd_nxt  = rd_q + PW'(do_pop);

  // Flags are registered from the next pointer values so they track the pointers exactly.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr_q  <= wr_nxt;
      rd_q  <= rd_nxt;
      full  <= (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]) && (wr_nxt[AW] != rd_nxt[AW]);
      empty <= (wr_nxt == rd_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_q[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/alu_cmd_driver.sv
// Handshake-driven master for the sequential ALU: FIFO-buffered commands are
// issued one at a time, results returned on a valid/ready response port.
// Optional statistics counters: define ALU_CMD_DRIVER_STATS_EN.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 63,
  parameter int unsigned OPW     = OPW_DEFAULT
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [OPW-1:0]      cmd_opA,
  input  logic [OPW-1:0]      cmd_opB,
  input  logic [OPCODE_W-1:0] cmd_opcode,
  output logic [OPW-1:0]      alu_opA,
  output logic [OPW-1:0]      alu_opB,
  output logic [OPCODE_W-1:0] alu_opcode,
  output logic                alu_en,
  input  logic [2*OPW-1:0]    alu_res,
  input  logic                alu_done,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [2*OPW-1:0]    rsp_res,
  output logic [OPCODE_W-1:0] rsp_opcode,
  output logic                rsp_err,
  output logic                busy
`ifdef ALU_CMD_DRIVER_STATS_EN
  ,
  output logic [15:0]         stat_ops,
  output logic [7:0]          stat_timeouts
`endif
);

  localparam int unsigned RESW = 2 * OPW;
  localparam int unsigned CMDW = 2 * OPW + OPCODE_W;
  localparam int unsigned CNTW = $clog2(TIMEOUT + 1);

  state_t              state_q;
  state_t              state_nxt;
  logic [CNTW-1:0]     cnt_q;
  logic [CNTW-1:0]     cnt_d;
  logic                timeout_hit;

  logic [CMDW-1:0]     fifo_wdata;
  logic [CMDW-1:0]     fifo_rdata;
  logic                fifo_push;
  logic                fifo_pop;
  logic                fifo_full;
  logic                fifo_empty;

  logic [OPW-1:0]      alu_opA_d;
  logic [OPW-1:0]      alu_opB_d;
  logic [OPCODE_W-1:0] alu_opcode_d;
  logic                alu_en_d;
  logic                rsp_valid_d;
  logic [RESW-1:0]     rsp_res_d;
  logic [OPCODE_W-1:0] rsp_opcode_d;
  logic                rsp_err_d;

  assign fifo_wdata = {cmd_opA, cmd_opB, cmd_opcode};
  assign fifo_push  = cmd_valid && cmd_ready;
  assign cmd_ready  = ~fifo_full;
  assign busy       = (state_q != S_IDLE) || !fifo_empty;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMDW)
  ) u_cmd_fifo (
    .clk   (clk),
    .nrst  (nrst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Counter value one short of TIMEOUT: the next idle WAIT cycle aborts.
  assign timeout_hit = (cnt_q == CNTW'(TIMEOUT - 1));

  // State and output registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      alu_opA    <= '0;
      alu_opB    <= '0;
      alu_opcode <= '0;
      alu_en     <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_res    <= '0;
      rsp_opcode <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      cnt_q      <= cnt_d;
      alu_opA    <= alu_opA_d;
      alu_opB    <= alu_opB_d;
      alu_opcode <= alu_opcode_d;
      alu_en     <= alu_en_d;
      rsp_valid  <= rsp_valid_d;
      rsp_res    <= rsp_res_d;
      rsp_opcode <= rsp_opcode_d;
      rsp_err    <= rsp_err_d;
    end
  end

  // Next-state logic. WAIT is only entered after the en cycle, so a done
  // coincident with en is never seen.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (!fifo_empty) state_nxt = S_ISSUE;
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (alu_done || timeout_hit) state_nxt = S_RESP;
      S_RESP:  if (rsp_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Output logic; operands are only reloaded on a pop so they stay stable
  // from ISSUE until the response is accepted.
  always_comb begin
    fifo_pop     = 1'b0;
    cnt_d        = cnt_q;
    alu_opA_d    = alu_opA;
    alu_opB_d    = alu_opB;
    alu_opcode_d = alu_opcode;
    alu_en_d     = 1'b0;
    rsp_valid_d  = rsp_valid;
    rsp_res_d    = rsp_res;
    rsp_opcode_d = rsp_opcode;
    rsp_err_d    = rsp_err;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          {alu_opA_d, alu_opB_d, alu_opcode_d} = fifo_rdata;
          alu_en_d = 1'b1;
        end
      end
      S_ISSUE: begin
        cnt_d = '0;
      end
      S_WAIT: begin
        if (alu_done) begin
          rsp_valid_d  = 1'b1;
          rsp_res_d    = alu_res;
          rsp_err_d    = 1'b0;
          rsp_opcode_d = alu_opcode;
        end else if (timeout_hit) begin
          rsp_valid_d  = 1'b1;
          rsp_res_d    = '0;
          rsp_err_d    = 1'b1;
          rsp_opcode_d = alu_opcode;
        end else begin
          cnt_d = cnt_q + CNTW'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) rsp_valid_d = 1'b0;
      end
      default: begin
      end
    endcase
  end

`ifdef ALU_CMD_DRIVER_STATS_EN
  logic rsp_fire;
  assign rsp_fire = rsp_valid && rsp_ready;

  // Saturating completion and timeout counters.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stat_ops      <= '0;
      stat_timeouts <= '0;
    end else if (rsp_fire) begin
      if (stat_ops != '1) stat_ops <= stat_ops + 16'(1);
      if (rsp_err && (stat_timeouts != '1)) stat_timeouts <= stat_timeouts + 8'(1);
    end
  end
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural ALU whose done pulse
// follows en by a programmable number of cycles.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 63;
  localparam int unsigned OPW     = 16;

  logic        clk = 1'b0;
  logic        nrst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_opA = '0;
  logic [15:0] cmd_opB = '0;
  logic [1:0]  cmd_opcode = '0;
  logic [15:0] alu_opA;
  logic [15:0] alu_opB;
  logic [1:0]  alu_opcode;
  logic        alu_en;
  logic [31:0] alu_res;
  logic        alu_done;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_res;
  logic [1:0]  rsp_opcode;
  logic        rsp_err;
  logic        busy;
`ifdef ALU_CMD_DRIVER_STATS_EN
  logic [15:0] stat_ops;
  logic [7:0]  stat_timeouts;
`endif

  alu_cmd_driver #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .OPW     (OPW)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_opA    (cmd_opA),
    .cmd_opB    (cmd_opB),
    .cmd_opcode (cmd_opcode),
    .alu_opA    (alu_opA),
    .alu_opB    (alu_opB),
    .alu_opcode (alu_opcode),
    .alu_en     (alu_en),
    .alu_res    (alu_res),
    .alu_done   (alu_done),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_res    (rsp_res),
    .rsp_opcode (rsp_opcode),
    .rsp_err    (rsp_err),
    .busy       (busy)
`ifdef ALU_CMD_DRIVER_STATS_EN
    ,
    .stat_ops      (stat_ops),
    .stat_timeouts (stat_timeouts)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural ALU: done pulses model_n cycles after en (0 = never);
  // model_early also raises done during the en cycle itself.
  int          model_n = 1;
  bit          model_early = 1'b0;
  int          rem;
  logic        done_q;
  logic [31:0] res_q;

  function automatic logic [31:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                         input logic [1:0] op);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = {{16{a[15]}}, a};
    sb = {{16{b[15]}}, b};
    case (op)
      2'b00:   return sa + sb;
      2'b01:   return sa * sb;
      2'b10:   return (sb == 0) ? 32'hFFFF_FFFF : sa / sb;
      default: return (sa > sb) ? 32'd1 : ((sa < sb) ? 32'hFFFF_FFFF : 32'd0);
    endcase
  endfunction

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      rem    <= 0;
      done_q <= 1'b0;
      res_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (alu_en) begin
        res_q  <= alu_fn(alu_opA, alu_opB, alu_opcode);
        rem    <= model_n - 1;
        done_q <= (model_n == 1);
      end else if (rem > 0) begin
        rem    <= rem - 1;
        done_q <= (rem == 1);
      end
    end
  end

  assign alu_done = done_q | (model_early & alu_en);
  assign alu_res  = alu_en ? 32'hBAD0_BAD0 : res_q;

  // Response and en monitors.
  int          cyc = 0;
  int          rsp_count = 0;
  int          en_count = 0;
  logic [31:0] q_res[$];
  logic        q_err[$];
  int          en_times[$];

  always @(posedge clk) begin
    cyc++;
    if (nrst && rsp_valid && rsp_ready) begin
      q_res.push_back(rsp_res);
      q_err.push_back(rsp_err);
      rsp_count++;
    end
    if (nrst && alu_en) begin
      en_count++;
      en_times.push_back(cyc);
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    int          n;
    bit          early;
    logic [31:0] exp_res;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  // Push one command with rsp_ready high and check the whole transaction.
  // Latency counts clock edges from the push edge to rsp_valid inclusive.
  task automatic do_single(input string tag, input vec_t v);
    int lat;
    int en0;
    model_n     = v.n;
    model_early = v.early;
    en0         = en_count;
    @(negedge clk);
    cmd_valid  = 1'b1;
    cmd_opA    = v.a;
    cmd_opB    = v.b;
    cmd_opcode = v.op;
    rsp_ready  = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
    check({tag, "_res"}, rsp_res, v.exp_res);
    check({tag, "_err"}, 32'(rsp_err), 32'(v.exp_err));
    check({tag, "_rsp_opcode"}, 32'(rsp_opcode), 32'(v.op));
    check({tag, "_alu_opA_held"}, 32'(alu_opA), 32'(v.a));
    check({tag, "_alu_opB_held"}, 32'(alu_opB), 32'(v.b));
    check({tag, "_en_pulses"}, 32'(en_count - en0), 32'd1);
    @(posedge clk);
    #1;
    check({tag, "_rsp_dropped"}, 32'(rsp_valid), 32'd0);
    model_early = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int e0;
    int waitc;
    logic acc;
    vec_t fresh;

    // a, b, op, N, early, expected result, expected err, expected latency
    vecs[0] = '{16'd111,  16'd135,  2'b00, 1,  1'b0, 32'd246,        1'b0, 4};
    vecs[1] = '{16'd135,  16'd111,  2'b01, 17, 1'b0, 32'h0000_3A89,  1'b0, 20};
    vecs[2] = '{16'd135,  16'hFF91, 2'b01, 17, 1'b0, 32'hFFFF_C577,  1'b0, 20};
    vecs[3] = '{16'h7EED, 16'h0105, 2'b10, 3,  1'b0, 32'h0000_007C,  1'b0, 6};
    vecs[4] = '{16'd5,    16'd6,    2'b00, 0,  1'b0, 32'd0,          1'b1, 3 + TIMEOUT};
    vecs[5] = '{16'd135,  16'd111,  2'b11, 1,  1'b0, 32'd1,          1'b0, 4};
    vecs[6] = '{16'hFF91, 16'd135,  2'b11, 2,  1'b0, 32'hFFFF_FFFF,  1'b0, 5};
    vecs[7] = '{16'd111,  16'd135,  2'b00, 2,  1'b1, 32'd246,        1'b0, 5};

    #3 nrst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_cmd_ready", 32'(cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_alu_en", 32'(alu_en), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 8; i++) begin
      do_single($sformatf("vec%0d", i), vecs[i]);
      repeat (2) @(posedge clk);
    end

    // Back-to-back multiplies.
    model_n   = 17;
    rsp_ready = 1'b1;
    c0 = rsp_count;
    e0 = en_times.size();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opA = 16'd135; cmd_opB = 16'd111; cmd_opcode = 2'b01;
    @(negedge clk);
    cmd_opB = 16'hFF91;
    @(negedge clk);
    cmd_valid = 1'b0;
    waitc = 0;
    while (rsp_count < c0 + 2 && waitc < 200) begin
      @(posedge clk);
      waitc++;
    end
    check("b2b_rsp_count", 32'(rsp_count - c0), 32'd2);
    if (rsp_count >= c0 + 2) begin
      check("b2b_rsp0", q_res[c0], 32'h0000_3A89);
      check("b2b_rsp1", q_res[c0+1], 32'hFFFF_C577);
    end
    if (en_times.size() >= e0 + 2) begin
      check("b2b_en_gap_ge19", 32'(en_times[e0+1] - en_times[e0] >= 19), 32'd1);
    end

    // Backpressure: response held, FIFO fills, 6th command refused.
    repeat (3) @(posedge clk);
    model_n   = 1;
    rsp_ready = 1'b0;
    c0 = rsp_count;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmd_valid  = 1'b1;
      cmd_opA    = 16'h7EED - 16'(i * 261);
      cmd_opB    = 16'h0105;
      cmd_opcode = 2'b10;
      acc = cmd_ready;
      check($sformatf("bp_accept%0d", i), 32'(acc), (i < 5) ? 32'd1 : 32'd0);
    end
    check("bp_rsp_valid_held", 32'(rsp_valid), 32'd1);
    check("bp_rsp_res_held", rsp_res, 32'h0000_007C);
    check("bp_busy", 32'(busy), 32'd1);
    repeat (3) @(negedge clk);
    check("bp_ready_still_low", 32'(cmd_ready), 32'd0);
    check("bp_res_stable", rsp_res, 32'h0000_007C);
    cmd_valid = 1'b0;
    check("bp_nothing_consumed", 32'(rsp_count - c0), 32'd0);
    rsp_ready = 1'b1;
    waitc = 0;
    while (rsp_count < c0 + 5 && waitc < 300) begin
      @(posedge clk);
      waitc++;
    end
    repeat (20) @(posedge clk);
    #1;
    check("bp_drain_count", 32'(rsp_count - c0), 32'd5);
    if (rsp_count >= c0 + 5) begin
      for (int k = 0; k < 5; k++) begin
        check($sformatf("bp_drain%0d", k), q_res[c0+k], 32'(124 - k));
      end
    end
    check("bp_idle_after_drain", 32'(busy), 32'd0);

    // Asynchronous reset during WAIT of a multiply.
    model_n = 17;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opA = 16'd135; cmd_opB = 16'd111; cmd_opcode = 2'b01;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    check("mid_pre_alu_opA", 32'(alu_opA), 32'd135);
    nrst = 1'b0;
    #1;
    check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("mid_rst_alu_opA", 32'(alu_opA), 32'd0);
    check("mid_rst_alu_opB", 32'(alu_opB), 32'd0);
    check("mid_rst_alu_opcode", 32'(alu_opcode), 32'd0);
    check("mid_rst_alu_en", 32'(alu_en), 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_rsp_res", rsp_res, 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    c0 = rsp_count;
    @(negedge clk);
    nrst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("mid_no_response", 32'(rsp_count - c0), 32'd0);
    check("mid_rsp_valid_low", 32'(rsp_valid), 32'd0);
    fresh = '{16'd135, 16'd111, 2'b11, 1, 1'b0, 32'd1, 1'b0, 4};
    do_single("post_reset_cmp", fresh);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
